// File: rtl/dmix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmix_pkg
// Description : Shared definitions for the volume mixer: FSM states, gain,
//               ack-timeout and output saturation constants.
// Revision    : 1.0 - initial release
// ============================================================================
package dmix_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POP  = 3'd1,
        WAIT = 3'd2,
        MAC  = 3'd3,
        OUT  = 3'd4
    } mix_state_t;

    localparam logic [15:0]        C_UNITY_GAIN = 16'h8000;
    localparam int                 C_TIMEOUT    = 3;
    localparam logic signed [23:0] C_SAT_MAX    = 24'sh7FFFFF;
    localparam logic signed [23:0] C_SAT_MIN    = 24'sh800000;

endpackage : dmix_pkg
`default_nettype wire

// File: rtl/mix_mac.sv
`default_nettype none
// ============================================================================
// Module      : mix_mac
// Description : Scales one signed 24-bit sample by an unsigned Q1.15 gain,
//               floors by 2^15 and gates the result with the channel mute.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_mac (
    input  logic signed [23:0] sample,
    input  logic        [15:0] gain,
    input  logic               mute,
    output logic signed [25:0] term
);

    logic signed [16:0] w_gain_s;
    logic signed [40:0] w_product;
    logic signed [40:0] w_shifted;
    logic               w_unused_bits;

    assign w_gain_s  = signed'({1'b0, gain});
    assign w_product = sample * w_gain_s;
    assign w_shifted = w_product >>> 15;

    // |sample * gain| < 2^39, so after the shift the value fits in 26 bits
    assign term          = mute ? '0 : w_shifted[25:0];
    assign w_unused_bits = ^w_shifted[40:26];

endmodule : mix_mac
`default_nettype wire

// File: rtl/volume_mixer.sv
`default_nettype none
// ============================================================================
// Module      : volume_mixer
// Description : Per-frame sequential mixer: pops every channel in turn, scales
//               it by its gain and accumulates onto the left or right bus.
// Revision    : 1.0 - initial release
// ============================================================================
module volume_mixer
    import dmix_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int NUM_CH_LOG2 = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   strobe_i,
    input  logic [16*NUM_CH-1:0]   vol_i,
    input  logic [NUM_CH-1:0]      pan_i,
    input  logic [NUM_CH-1:0]      mute_i,
    output logic [NUM_CH-1:0]      pop_o,
    input  logic [NUM_CH-1:0]      ack_i,
    input  logic [24*NUM_CH-1:0]   data_i,
    output logic [23:0]            data_l_o,
    output logic [23:0]            data_r_o,
    output logic                   ack_o,
    output logic                   overrun_o,
    output logic [NUM_CH-1:0]      miss_o
);

    localparam int C_ACC_W = 26 + NUM_CH_LOG2;

    mix_state_t                 r_state, w_state_next;
    logic [NUM_CH_LOG2-1:0]     r_ch;
    logic [1:0]                 r_wait_cnt;
    logic signed [23:0]         r_sample;
    logic signed [C_ACC_W-1:0]  r_acc_l, r_acc_r;
    logic signed [C_ACC_W-1:0]  w_acc_l_next, w_acc_r_next;
    logic [23:0]                r_data_l, r_data_r;
    logic                       r_overrun;
    logic [NUM_CH-1:0]          r_miss;

    logic                       w_ack_hit, w_timeout, w_last_ch;
    logic signed [25:0]         w_term;
    logic signed [C_ACC_W-1:0]  w_term_ext;

    assign w_ack_hit = ack_i[r_ch];
    assign w_timeout = (r_wait_cnt == 2'(C_TIMEOUT - 1));
    assign w_last_ch = (r_ch == NUM_CH_LOG2'(NUM_CH - 1));

    mix_mac u_mac (
        .sample (r_sample),
        .gain   (vol_i[16*r_ch +: 16]),
        .mute   (mute_i[r_ch]),
        .term   (w_term)
    );

    assign w_term_ext   = C_ACC_W'(w_term);
    assign w_acc_l_next = pan_i[r_ch] ? r_acc_l : r_acc_l + w_term_ext;
    assign w_acc_r_next = pan_i[r_ch] ? r_acc_r + w_term_ext : r_acc_r;

    function automatic logic [23:0] sat24(input logic signed [C_ACC_W-1:0] v);
        if (v > C_ACC_W'(C_SAT_MAX))
            return C_SAT_MAX;
        else if (v < C_ACC_W'(C_SAT_MIN))
            return C_SAT_MIN;
        else
            return v[23:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        pop_o        = '0;
        ack_o        = 1'b0;
        case (r_state)
            IDLE: if (strobe_i) w_state_next = POP;
            POP: begin
                pop_o[r_ch]  = 1'b1;
                w_state_next = WAIT;
            end
            WAIT: if (w_ack_hit || w_timeout) w_state_next = MAC;
            MAC:  w_state_next = w_last_ch ? OUT : POP;
            OUT: begin
                ack_o        = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch       <= '0;
            r_wait_cnt <= '0;
            r_sample   <= '0;
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            r_data_l   <= '0;
            r_data_r   <= '0;
            r_overrun  <= 1'b0;
            r_miss     <= '0;
        end else begin
            r_overrun <= strobe_i && (r_state != IDLE);
            case (r_state)
                IDLE: if (strobe_i) begin
                    r_acc_l <= '0;
                    r_acc_r <= '0;
                    r_ch    <= '0;
                end
                POP: r_wait_cnt <= '0;
                WAIT: begin
                    if (w_ack_hit) begin
                        r_sample <= data_i[24*r_ch +: 24];
                    end else if (w_timeout) begin
                        r_sample     <= '0;
                        r_miss[r_ch] <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end
                MAC: begin
                    r_acc_l <= w_acc_l_next;
                    r_acc_r <= w_acc_r_next;
                    // Outputs load with the final sum so they are valid while ack_o is high
                    if (w_last_ch) begin
                        r_data_l <= sat24(w_acc_l_next);
                        r_data_r <= sat24(w_acc_r_next);
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_l_o  = r_data_l;
    assign data_r_o  = r_data_r;
    assign overrun_o = r_overrun;
    assign miss_o    = r_miss;

endmodule : volume_mixer
`default_nettype wire

// File: tb/tb_volume_mixer.sv
`default_nettype none
// ============================================================================
// Module      : tb_volume_mixer
// Description : Directed self-checking bench for volume_mixer (NUM_CH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_volume_mixer;
    import dmix_pkg::*;

    localparam int NUM_CH = 8;

    logic                  clk;
    logic                  rst;
    logic                  strobe_i;
    logic [16*NUM_CH-1:0]  vol_i;
    logic [NUM_CH-1:0]     pan_i;
    logic [NUM_CH-1:0]     mute_i;
    logic [NUM_CH-1:0]     pop_o;
    logic [NUM_CH-1:0]     ack_i;
    logic [24*NUM_CH-1:0]  data_i;
    logic [23:0]           data_l_o;
    logic [23:0]           data_r_o;
    logic                  ack_o;
    logic                  overrun_o;
    logic [NUM_CH-1:0]     miss_o;

    int n_cmp = 0;
    int n_bad = 0;
    int pop_cnt [NUM_CH];
    int pop_multi;
    logic [NUM_CH-1:0] withhold;
    logic [NUM_CH-1:0] pend;

    volume_mixer #(.NUM_CH(NUM_CH), .NUM_CH_LOG2(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .strobe_i  (strobe_i),
        .vol_i     (vol_i),
        .pan_i     (pan_i),
        .mute_i    (mute_i),
        .pop_o     (pop_o),
        .ack_i     (ack_i),
        .data_i    (data_i),
        .data_l_o  (data_l_o),
        .data_r_o  (data_r_o),
        .ack_o     (ack_o),
        .overrun_o (overrun_o),
        .miss_o    (miss_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream model: answers each pop one cycle later unless withheld
    initial begin
        pend  = '0;
        ack_i = '0;
        forever begin
            @(posedge clk);
            #1;
            ack_i = pend;
            pend  = pop_o & ~withhold;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_cfg(input logic [23:0] sample, input logic [15:0] gain,
                           input logic [NUM_CH-1:0] pan, input logic [NUM_CH-1:0] mute);
        for (int c = 0; c < NUM_CH; c++) begin
            data_i[24*c +: 24] = sample;
            vol_i[16*c +: 16]  = gain;
        end
        pan_i  = pan;
        mute_i = mute;
    endtask

    task automatic run_frame(input int max_cyc, input int strobe2_at, input int rst_at,
                             output int ack_cyc, output int n_ack,
                             output int ovr_cyc, output int n_ovr, output int rst_bad);
        ack_cyc = -1; n_ack = 0; ovr_cyc = -1; n_ovr = 0; rst_bad = 0;
        pop_multi = 0;
        for (int c = 0; c < NUM_CH; c++) pop_cnt[c] = 0;
        @(posedge clk); #1 strobe_i = 1'b1;
        @(posedge clk); #1 strobe_i = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            if (ack_o) begin
                n_ack++;
                if (ack_cyc < 0) ack_cyc = cyc;
            end
            if (overrun_o) begin
                n_ovr++;
                if (ovr_cyc < 0) ovr_cyc = cyc;
            end
            if ($countones(pop_o) > 1) pop_multi++;
            for (int c = 0; c < NUM_CH; c++) pop_cnt[c] += int'(pop_o[c]);
            strobe_i = (cyc == strobe2_at);
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                if (pop_o !== '0 || ack_o !== 1'b0 || miss_o !== '0 || data_l_o !== '0)
                    rst_bad = 1;
            end
            if (cyc == rst_at + 2) rst = 1'b0;
            @(posedge clk); #1;
        end
        strobe_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; strobe_i = 1'b0; withhold = '0;
        set_cfg(24'h0, 16'h0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (pop_o !== '0) begin n_bad++; $display("FAIL reset_pop: got %h want 00", pop_o); end
        n_cmp++; if (ack_o !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        n_cmp++; if (overrun_o !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
        n_cmp++; if (miss_o !== '0) begin n_bad++; $display("FAIL reset_miss: got %h want 00", miss_o); end
        n_cmp++; if (data_l_o !== 24'h0 || data_r_o !== 24'h0) begin
            n_bad++; $display("FAIL reset_data: got %h/%h want 000000/000000", data_l_o, data_r_o); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_unity();
        int ac, na, oc, no, rb;
        set_cfg(24'h000100, C_UNITY_GAIN, 8'hF0, 8'h00);
        run_frame(30, 999, 999, ac, na, oc, no, rb);
        n_cmp++; if (ac !== 25) begin n_bad++; $display("FAIL unity_latency: got %0d want 25", ac); end
        n_cmp++; if (na !== 1) begin n_bad++; $display("FAIL unity_ack_count: got %0d want 1", na); end
        n_cmp++; if (data_l_o !== 24'h000400) begin n_bad++; $display("FAIL unity_left: got %h want 000400", data_l_o); end
        n_cmp++; if (data_r_o !== 24'h000400) begin n_bad++; $display("FAIL unity_right: got %h want 000400", data_r_o); end
        n_cmp++; if (pop_multi !== 0 || pop_cnt[0] !== 1 || pop_cnt[7] !== 1) begin
            n_bad++; $display("FAIL unity_pops: multi %0d ch0 %0d ch7 %0d want 0 1 1", pop_multi, pop_cnt[0], pop_cnt[7]); end
        // Outputs must hold while idle even when inputs change
        set_cfg(24'h123456, 16'h1234, 8'h00, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        n_cmp++; if (data_l_o !== 24'h000400 || data_r_o !== 24'h000400) begin
            n_bad++; $display("FAIL hold_data: got %h/%h want 000400/000400", data_l_o, data_r_o); end
    endtask

    task automatic test_saturation();
        int ac, na, oc, no, rb;
        set_cfg(24'h7FFFFF, 16'hFFFF, 8'h00, 8'h00);
        run_frame(30, 999, 999, ac, na, oc, no, rb);
        n_cmp++; if (data_l_o !== 24'h7FFFFF) begin n_bad++; $display("FAIL sat_pos_left: got %h want 7fffff", data_l_o); end
        n_cmp++; if (data_r_o !== 24'h000000) begin n_bad++; $display("FAIL sat_pos_right: got %h want 000000", data_r_o); end
        set_cfg(24'h800000, 16'hFFFF, 8'h00, 8'h00);
        run_frame(30, 999, 999, ac, na, oc, no, rb);
        n_cmp++; if (data_l_o !== 24'h800000) begin n_bad++; $display("FAIL sat_neg_left: got %h want 800000", data_l_o); end
    endtask

    task automatic test_mute();
        int ac, na, oc, no, rb;
        set_cfg(24'h001000, C_UNITY_GAIN, 8'h00, 8'h04);
        run_frame(30, 999, 999, ac, na, oc, no, rb);
        n_cmp++; if (data_l_o !== 24'h007000) begin n_bad++; $display("FAIL mute_left: got %h want 007000", data_l_o); end
        n_cmp++; if (data_r_o !== 24'h000000) begin n_bad++; $display("FAIL mute_right: got %h want 000000", data_r_o); end
        n_cmp++; if (pop_cnt[2] !== 1) begin n_bad++; $display("FAIL mute_pop2: got %0d want 1", pop_cnt[2]); end
    endtask

    task automatic test_gain_floor();
        int ac, na, oc, no, rb;
        // -3 * 0.5 = -1.5 -> -2 ; +3 * 0.5 = 1.5 -> 1
        set_cfg(24'h0, 16'h4000, 8'h02, 8'hFC);
        data_i[23:0]  = 24'hFFFFFD;
        data_i[47:24] = 24'h000003;
        run_frame(30, 999, 999, ac, na, oc, no, rb);
        n_cmp++; if (data_l_o !== 24'hFFFFFE) begin n_bad++; $display("FAIL floor_left: got %h want fffffe", data_l_o); end
        n_cmp++; if (data_r_o !== 24'h000001) begin n_bad++; $display("FAIL floor_right: got %h want 000001", data_r_o); end
    endtask

    task automatic test_overrun();
        int ac, na, oc, no, rb;
        set_cfg(24'h000100, C_UNITY_GAIN, 8'hF0, 8'h00);
        run_frame(45, 10, 999, ac, na, oc, no, rb);
        n_cmp++; if (oc !== 11) begin n_bad++; $display("FAIL overrun_cycle: got %0d want 11", oc); end
        n_cmp++; if (no !== 1) begin n_bad++; $display("FAIL overrun_count: got %0d want 1", no); end
        n_cmp++; if (na !== 1 || ac !== 25) begin n_bad++; $display("FAIL overrun_ack: got %0d acks at %0d want 1 at 25", na, ac); end
        n_cmp++; if (data_l_o !== 24'h000400 || data_r_o !== 24'h000400) begin
            n_bad++; $display("FAIL overrun_data: got %h/%h want 000400/000400", data_l_o, data_r_o); end
    endtask

    task automatic test_timeout();
        int ac, na, oc, no, rb;
        set_cfg(24'h001000, C_UNITY_GAIN, 8'h00, 8'h00);
        withhold = 8'h20;
        run_frame(32, 999, 999, ac, na, oc, no, rb);
        withhold = '0;
        n_cmp++; if (miss_o !== 8'h20) begin n_bad++; $display("FAIL timeout_miss: got %h want 20", miss_o); end
        n_cmp++; if (data_l_o !== 24'h007000) begin n_bad++; $display("FAIL timeout_left: got %h want 007000", data_l_o); end
        n_cmp++; if (ac !== 27) begin n_bad++; $display("FAIL timeout_latency: got %0d want 27", ac); end
    endtask

    task automatic test_reset_mid_frame();
        int ac, na, oc, no, rb, tot;
        set_cfg(24'h000100, C_UNITY_GAIN, 8'hF0, 8'h00);
        run_frame(30, 999, 12, ac, na, oc, no, rb);
        tot = 0;
        for (int c = 0; c < NUM_CH; c++) tot += pop_cnt[c];
        n_cmp++; if (rb !== 0) begin n_bad++; $display("FAIL midrst_outputs: got flag %0d want 0", rb); end
        n_cmp++; if (na !== 0) begin n_bad++; $display("FAIL midrst_ack: got %0d acks want 0", na); end
        n_cmp++; if (tot !== 4) begin n_bad++; $display("FAIL midrst_pops: got %0d want 4", tot); end
        set_cfg(24'h000200, C_UNITY_GAIN, 8'h0F, 8'h00);
        run_frame(30, 999, 999, ac, na, oc, no, rb);
        n_cmp++; if (ac !== 25 || na !== 1) begin n_bad++; $display("FAIL postrst_ack: got %0d acks at %0d want 1 at 25", na, ac); end
        n_cmp++; if (data_l_o !== 24'h000800 || data_r_o !== 24'h000800) begin
            n_bad++; $display("FAIL postrst_data: got %h/%h want 000800/000800", data_l_o, data_r_o); end
        n_cmp++; if (miss_o !== '0) begin n_bad++; $display("FAIL postrst_miss: got %h want 00", miss_o); end
    endtask

    initial begin
        test_reset();
        test_unity();
        test_saturation();
        test_mute();
        test_gain_floor();
        test_overrun();
        test_timeout();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_volume_mixer
`default_nettype wire
